alu_lane_sequencer: RTL and testbench
=====================================

Name: alu_lane_sequencer

Overview:
Execute-stage sequencer that sits directly upstream of the combinational 8-bit ALU. It accepts one vector instruction of LANES packed lanes through a valid/ready handshake. It drives the ALU one lane per clock and collects each lane result into a packed result vector. It then presents that vector, with zero and error flags, to the write-back stage through a second valid/ready handshake.

Parameters:
BITS, 8, lane width; matches the ALU data width.
ALUOP, 4, ALU function code width.
LANES, 4, number of lanes per vector instruction (at least 2).

Ports:
clk  input  1  clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
inValid  input  1  instruction valid from decode.
inReady  output  1  sequencer can accept an instruction.
inFunction  input  ALUOP  ALU function code.
inVectorA  input  LANES*BITS  operand A; lane i = bits [i*BITS +: BITS].
inVectorB  input  LANES*BITS  operand B; same packing as inVectorA.
aluFunction  output  ALUOP  function code to the ALU.
aluOperandA  output  BITS  current lane operand A to the ALU.
aluOperandB  output  BITS  current lane operand B to the ALU.
aluResult  input  BITS  combinational ALU result for the current lane.
outValid  output  1  result vector valid to write-back.
outReady  input  1  write-back accepts the result.
outVector  output  LANES*BITS  packed lane results.
outZero  output  1  set when every bit of outVector is 0.
outError  output  1  set when the instruction used an illegal function code.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE; outValid=0, outVector=0, outZero=0, outError=0; aluFunction=0, aluOperandA=0, aluOperandB=0; lane index=0.
- inReady is combinational and equals (state==IDLE). It may read 1 while rst_n is low, but inValid is ignored during reset.
- States: IDLE, RUN, DONE.
- IDLE:
  - An instruction is accepted at a rising edge when inValid && inReady. On accept, the block latches inFunction, inVectorA and inVectorB and clears the lane index.
  - Legal function codes are 1..11. A legal code moves the block to RUN.
  - An illegal code (0, 12..15) moves the block straight to DONE with outError=1 and outVector=0. No ALU cycles are issued in this case.
- RUN:
  - Each cycle the block drives aluFunction with the latched code. aluOperandA and aluOperandB carry lane[idx] of the latched A and B.
  - At the next edge, aluResult is written into lane idx of outVector and idx increments.
  - After the edge that captures lane LANES-1, the state goes to DONE.
  - outVector lanes not yet processed read 0. outVector is cleared on accept.
- DONE:
  - outValid=1. outVector, outZero and outError hold stable until the edge where outReady=1.
  - At that edge the state returns to IDLE, outValid drops, and the flags clear.
- ALU drive outside RUN: aluFunction and both operands are 0 in IDLE and DONE. This keeps the ALU in its no-function case.
- Latency: for a legal opcode accepted at edge k, lanes are captured at edges k+1 through k+LANES, and outValid=1 after edge k+LANES. For an illegal opcode, outValid=1 after edge k+1.
- Throughput: one instruction per LANES+2 cycles with outReady tied high. A new accept needs the IDLE cycle after the DONE handshake; there is no overlap.
- Width rules:
  - Lane results take aluResult as-is, modulo 2^BITS (no saturation).
  - outZero is registered and updated together with the final lane capture. outZero=0 whenever outError=1.
- Backpressure: while DONE and outReady=0, inReady=0 and no new instruction is accepted.
- Reset mid-operation: asserting rst_n in any state returns the block to IDLE immediately with reset values. Partial results are discarded.

Test Plan:
- ADD (1), A=32'hFF302010, B=32'h01020304, outReady=1 -> aluOperandA sequence 10,20,30,FF; after 4 edges outVector=32'h00322314, outZero=0, outError=0; one cycle later inReady=1.
- SUB (2), A=B=32'h5A5A5A5A -> outVector=0, outZero=1, outValid 4 edges after accept.
- Illegal opcode 4'd12 -> outValid after 1 edge, outError=1, outVector=0; aluFunction stays 0 throughout.
- Backpressure: XOR (3), A=32'hF0F0F0F0, B=32'h0FF00FF0, outReady low for 5 cycles -> outVector=32'hFF00FF00 held stable, inReady=0, a second inValid is not accepted until after the outReady handshake.
- Reset mid-RUN: pull rst_n low after lane 1 is captured -> outValid=0, outVector=0, aluFunction=0, inReady=1; a following ADD completes correctly.
- Back-to-back: two ADDs with inValid held high and outReady=1 -> second accept occurs exactly one cycle after the first result handshake; both result vectors are correct.

Source files
------------

// File: rtl/alu_lane_sequencer.sv
// -----------------------------------------------------------------------------
// alu_lane_sequencer
//
// Execute-stage sequencer placed directly upstream of a combinational ALU.
// It accepts one vector instruction of LANES packed lanes, feeds the ALU one
// lane per clock, and collects each lane result into a packed vector. The
// vector is then offered to write-back with zero and error flags.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   inValid/inReady instruction handshake from decode (inReady = IDLE)
//   inFunction      ALU function code of the instruction
//   inVectorA/B     packed operands, lane i = bits [i*BITS +: BITS]
//   aluFunction     registered function code to the ALU (0 outside RUN)
//   aluOperandA/B   registered current-lane operands to the ALU
//   aluResult       combinational ALU result for the current lane
//   outValid/Ready  result handshake to write-back
//   outVector       packed lane results
//   outZero         every bit of outVector is 0 (never with outError)
//   outError        the instruction used an illegal function code
//
// Timing
//   Legal code accepted at edge k: lanes captured at edges k+1..k+LANES,
//   outValid high after edge k+LANES.
//   Illegal code accepted at edge k: one RUN cycle with the ALU held idle,
//   outValid high after edge k+1 with outError=1 and outVector=0.
// -----------------------------------------------------------------------------
module alu_lane_sequencer #(
  parameter int BITS  = 8,
  parameter int ALUOP = 4,
  parameter int LANES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [ALUOP-1:0]      inFunction,
  input  logic [LANES*BITS-1:0] inVectorA,
  input  logic [LANES*BITS-1:0] inVectorB,
  output logic [ALUOP-1:0]      aluFunction,
  output logic [BITS-1:0]       aluOperandA,
  output logic [BITS-1:0]       aluOperandB,
  input  logic [BITS-1:0]       aluResult,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [LANES*BITS-1:0] outVector,
  output logic                  outZero,
  output logic                  outError
);

  localparam int VW    = LANES * BITS;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Legal function codes are 1..11; everything else is reported as an error.
  function automatic logic is_legal(input logic [ALUOP-1:0] f);
    return (f >= ALUOP'(1)) && (f <= ALUOP'(11));
  endfunction

  function automatic logic [BITS-1:0] lane_of(input logic [VW-1:0]    v,
                                              input logic [IDX_W-1:0] i);
    return v[int'(i)*BITS +: BITS];
  endfunction

  state_e            state_q,        state_d;
  logic [ALUOP-1:0]  func_q,         func_d;
  logic [VW-1:0]     vec_a_q,        vec_a_d;
  logic [VW-1:0]     vec_b_q,        vec_b_d;
  logic [IDX_W-1:0]  idx_q,          idx_d;
  logic              err_pend_q,     err_pend_d;
  logic [VW-1:0]     out_vector_q,   out_vector_d;
  logic              out_valid_q,    out_valid_d;
  logic              out_zero_q,     out_zero_d;
  logic              out_error_q,    out_error_d;
  logic [ALUOP-1:0]  alu_function_q, alu_function_d;
  logic [BITS-1:0]   alu_op_a_q,     alu_op_a_d;
  logic [BITS-1:0]   alu_op_b_q,     alu_op_b_d;
  logic [IDX_W-1:0]  next_idx;

  assign next_idx = idx_q + IDX_W'(1);

  // inReady is the only combinational output; during reset the state is IDLE
  // so it reads 1, but the reset holds every flop so inValid has no effect.
  assign inReady = (state_q == IDLE);

  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned; an unassigned path would infer a latch.
    state_d        = state_q;
    func_d         = func_q;
    vec_a_d        = vec_a_q;
    vec_b_d        = vec_b_q;
    idx_d          = idx_q;
    err_pend_d     = err_pend_q;
    out_vector_d   = out_vector_q;
    out_valid_d    = out_valid_q;
    out_zero_d     = out_zero_q;
    out_error_d    = out_error_q;
    alu_function_d = alu_function_q;
    alu_op_a_d     = alu_op_a_q;
    alu_op_b_d     = alu_op_b_q;

    unique case (state_q)
      IDLE: begin
        if (inValid) begin
          func_d       = inFunction;
          vec_a_d      = inVectorA;
          vec_b_d      = inVectorB;
          idx_d        = '0;
          out_vector_d = '0;
          out_zero_d   = 1'b0;
          out_error_d  = 1'b0;
          state_d      = RUN;
          if (is_legal(inFunction)) begin
            // Lane 0 is presented to the ALU in the first RUN cycle.
            err_pend_d     = 1'b0;
            alu_function_d = inFunction;
            alu_op_a_d     = lane_of(inVectorA, '0);
            alu_op_b_d     = lane_of(inVectorB, '0);
          end else begin
            // Illegal code: spend one RUN cycle with the ALU left at
            // function 0, then report the error from DONE.
            err_pend_d     = 1'b1;
            alu_function_d = '0;
            alu_op_a_d     = '0;
            alu_op_b_d     = '0;
          end
        end
      end

      RUN: begin
        if (err_pend_q) begin
          err_pend_d  = 1'b0;
          out_error_d = 1'b1;
          out_zero_d  = 1'b0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          // Results are taken as-is from the ALU, already modulo 2^BITS.
          out_vector_d[int'(idx_q)*BITS +: BITS] = aluResult;
          if (idx_q == LAST_IDX) begin
            idx_d          = '0;
            out_valid_d    = 1'b1;
            out_zero_d     = (out_vector_d == '0);
            alu_function_d = '0;
            alu_op_a_d     = '0;
            alu_op_b_d     = '0;
            state_d        = DONE;
          end else begin
            idx_d      = next_idx;
            alu_op_a_d = lane_of(vec_a_q, next_idx);
            alu_op_b_d = lane_of(vec_b_q, next_idx);
          end
        end
      end

      DONE: begin
        // Result and flags hold until write-back takes them.
        if (outReady) begin
          out_valid_d = 1'b0;
          out_zero_d  = 1'b0;
          out_error_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d        = IDLE;
        out_valid_d    = 1'b0;
        out_zero_d     = 1'b0;
        out_error_d    = 1'b0;
        alu_function_d = '0;
        alu_op_a_d     = '0;
        alu_op_b_d     = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      // NOTE: the operand latches are plain registers (not a memory array),
      // so they are reset with everything else; they are only read after an
      // accept overwrites them, but resetting keeps the state deterministic.
      func_q         <= '0;
      vec_a_q        <= '0;
      vec_b_q        <= '0;
      idx_q          <= '0;
      err_pend_q     <= 1'b0;
      out_vector_q   <= '0;
      out_valid_q    <= 1'b0;
      out_zero_q     <= 1'b0;
      out_error_q    <= 1'b0;
      alu_function_q <= '0;
      alu_op_a_q     <= '0;
      alu_op_b_q     <= '0;
    end else begin
      state_q        <= state_d;
      func_q         <= func_d;
      vec_a_q        <= vec_a_d;
      vec_b_q        <= vec_b_d;
      idx_q          <= idx_d;
      err_pend_q     <= err_pend_d;
      out_vector_q   <= out_vector_d;
      out_valid_q    <= out_valid_d;
      out_zero_q     <= out_zero_d;
      out_error_q    <= out_error_d;
      alu_function_q <= alu_function_d;
      alu_op_a_q     <= alu_op_a_d;
      alu_op_b_q     <= alu_op_b_d;
    end
  end

  assign aluFunction = alu_function_q;
  assign aluOperandA = alu_op_a_q;
  assign aluOperandB = alu_op_b_q;
  assign outValid    = out_valid_q;
  assign outVector   = out_vector_q;
  assign outZero     = out_zero_q;
  assign outError    = out_error_q;

endmodule

// File: tb/tb_alu_lane_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_lane_sequencer
//
// Self-checking bench for alu_lane_sequencer. A behavioural 8-bit ALU drives
// aluResult from the sequencer's ALU outputs; a reference model computes the
// expected result vector lane by lane from the instruction alone.
// -----------------------------------------------------------------------------
module tb_alu_lane_sequencer;

  localparam int BITS  = 8;
  localparam int ALUOP = 4;
  localparam int LANES = 4;
  localparam int VW    = LANES * BITS;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             inValid = 1'b0;
  logic             inReady;
  logic [ALUOP-1:0] inFunction = '0;
  logic [VW-1:0]    inVectorA = '0;
  logic [VW-1:0]    inVectorB = '0;
  logic [ALUOP-1:0] aluFunction;
  logic [BITS-1:0]  aluOperandA;
  logic [BITS-1:0]  aluOperandB;
  logic [BITS-1:0]  aluResult;
  logic             outValid;
  logic             outReady = 1'b1;
  logic [VW-1:0]    outVector;
  logic             outZero;
  logic             outError;

  int total = 0;
  int bad   = 0;

  alu_lane_sequencer #(.BITS(BITS), .ALUOP(ALUOP), .LANES(LANES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inValid     (inValid),
    .inReady     (inReady),
    .inFunction  (inFunction),
    .inVectorA   (inVectorA),
    .inVectorB   (inVectorB),
    .aluFunction (aluFunction),
    .aluOperandA (aluOperandA),
    .aluOperandB (aluOperandB),
    .aluResult   (aluResult),
    .outValid    (outValid),
    .outReady    (outReady),
    .outVector   (outVector),
    .outZero     (outZero),
    .outError    (outError)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; function 0 and unused codes give 0.
  function automatic logic [BITS-1:0] alu_fn(input logic [ALUOP-1:0] f,
                                             input logic [BITS-1:0] a,
                                             input logic [BITS-1:0] b);
    case (f)
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return a ^ b;
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return ~(a & b);
      4'd7:    return a << b[2:0];
      4'd8:    return a >> b[2:0];
      4'd9:    return (a < b) ? 8'd1 : 8'd0;
      4'd10:   return b - a;
      4'd11:   return a * b;
      default: return '0;
    endcase
  endfunction

  assign aluResult = alu_fn(aluFunction, aluOperandA, aluOperandB);

  function automatic logic [VW-1:0] ref_vec(input logic [ALUOP-1:0] f,
                                            input logic [VW-1:0] a,
                                            input logic [VW-1:0] b);
    logic [VW-1:0] r;
    r = '0;
    if (f >= 1 && f <= 11)
      for (int i = 0; i < LANES; i++)
        r[i*BITS +: BITS] = alu_fn(f, a[i*BITS +: BITS], b[i*BITS +: BITS]);
    return r;
  endfunction

  function automatic logic [VW-1:0] low_lanes(input logic [VW-1:0] v, input int n);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i*BITS +: BITS] = v[i*BITS +: BITS];
    return r;
  endfunction

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full instruction: accept, per-lane drive, result, optional backpressure.
  task automatic run_op(input string tag, input logic [ALUOP-1:0] f,
                        input logic [VW-1:0] a, input logic [VW-1:0] b,
                        input int hold);
    logic [VW-1:0] exp_v;
    logic          legal;
    int            n;
    legal = (f >= 1 && f <= 11);
    exp_v = ref_vec(f, a, b);
    outReady = (hold == 0);
    n = 0;
    while (!inReady && n < 50) begin
      tick();
      n++;
    end
    check($sformatf("%s ready_before", tag), inReady, 1);
    inValid = 1'b1; inFunction = f; inVectorA = a; inVectorB = b;
    tick();                                   // accept edge
    inValid = 1'b0;
    check($sformatf("%s busy", tag), inReady, 0);
    check($sformatf("%s cleared", tag), outVector, 0);
    if (legal) begin
      for (int i = 0; i < LANES; i++) begin
        check($sformatf("%s fn%0d", tag, i), aluFunction, f);
        check($sformatf("%s opa%0d", tag, i), aluOperandA, a[i*BITS +: BITS]);
        check($sformatf("%s opb%0d", tag, i), aluOperandB, b[i*BITS +: BITS]);
        check($sformatf("%s vld%0d", tag, i), outValid, 0);
        tick();
        if (i < LANES - 1)
          check($sformatf("%s part%0d", tag, i), outVector, low_lanes(exp_v, i + 1));
      end
    end else begin
      check($sformatf("%s errfn", tag), aluFunction, 0);
      check($sformatf("%s errvld", tag), outValid, 0);
      tick();
    end
    check($sformatf("%s valid", tag), outValid, 1);
    check($sformatf("%s vec", tag), outVector, exp_v);
    check($sformatf("%s zero", tag), outZero, (!legal) ? 1'b0 : (exp_v == '0));
    check($sformatf("%s err", tag), outError, !legal);
    check($sformatf("%s idlefn", tag), aluFunction, 0);
    for (int j = 0; j < hold; j++) begin
      inValid = 1'b1; inFunction = 4'd1;      // must not be accepted in DONE
      tick();
      check($sformatf("%s hold_vld%0d", tag, j), outValid, 1);
      check($sformatf("%s hold_vec%0d", tag, j), outVector, exp_v);
      check($sformatf("%s hold_rdy%0d", tag, j), inReady, 0);
      check($sformatf("%s hold_err%0d", tag, j), outError, !legal);
    end
    if (hold > 0) begin
      inValid = 1'b0;
      outReady = 1'b1;
    end
    tick();                                   // handshake edge
    check($sformatf("%s drop_vld", tag), outValid, 0);
    check($sformatf("%s drop_err", tag), outError, 0);
    check($sformatf("%s drop_zero", tag), outZero, 0);
    check($sformatf("%s ready_after", tag), inReady, 1);
    if (hold > 0) begin
      tick();
      check($sformatf("%s no_accept", tag), inReady, 1);
      check($sformatf("%s no_accept_fn", tag), aluFunction, 0);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] a1, b1, a2, b2, e1, e2;
    logic [ALUOP-1:0] rf;
    logic [VW-1:0]    ra, rb;

    // Reset state, with inValid asserted to show it is ignored.
    inValid = 1'b1; inFunction = 4'd1;
    #2;
    check("rst_valid", outValid, 0);
    check("rst_vec", outVector, 0);
    check("rst_zero", outZero, 0);
    check("rst_err", outError, 0);
    check("rst_fn", aluFunction, 0);
    check("rst_opa", aluOperandA, 0);
    check("rst_opb", aluOperandB, 0);
    check("rst_ready", inReady, 1);
    tick();
    check("rst_hold_fn", aluFunction, 0);
    inValid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", inReady, 1);

    // Directed cases.
    run_op("add", 4'd1, 32'hFF302010, 32'h01020304, 0);
    run_op("sub_zero", 4'd2, 32'h5A5A5A5A, 32'h5A5A5A5A, 0);
    run_op("illegal12", 4'd12, 32'h12345678, 32'h9ABCDEF0, 0);
    run_op("illegal0", 4'd0, 32'h11111111, 32'h22222222, 1);
    run_op("xor_bp", 4'd3, 32'hF0F0F0F0, 32'h0FF00FF0, 5);
    check("xor_model", ref_vec(4'd3, 32'hF0F0F0F0, 32'h0FF00FF0), 32'hFF00FF00);

    // Reset in the middle of RUN after lane 1 is captured.
    outReady = 1'b1;
    inValid = 1'b1; inFunction = 4'd1; inVectorA = 32'h04030201; inVectorB = 32'h10101010;
    tick();
    inValid = 1'b0;
    tick();
    tick();
    check("mid_part", outVector, 32'h00001211);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", outValid, 0);
    check("mid_rst_vec", outVector, 0);
    check("mid_rst_fn", aluFunction, 0);
    check("mid_rst_opa", aluOperandA, 0);
    check("mid_rst_ready", inReady, 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("add_after_rst", 4'd1, 32'h80FF7F01, 32'h80017F01, 0);

    // Back-to-back ADDs with inValid held high.
    a1 = 32'h01020304; b1 = 32'h10203040;
    a2 = 32'hA0B0C0D0; b2 = 32'h0A0B0C0D;
    e1 = ref_vec(4'd1, a1, b1);
    e2 = ref_vec(4'd1, a2, b2);
    outReady = 1'b1;
    inValid = 1'b1; inFunction = 4'd1; inVectorA = a1; inVectorB = b1;
    tick();                                   // first accept
    inVectorA = a2; inVectorB = b2;
    for (int i = 0; i < LANES; i++) tick();
    check("b2b_vld1", outValid, 1);
    check("b2b_vec1", outVector, e1);
    tick();                                   // first handshake
    check("b2b_idle", inReady, 1);
    check("b2b_drop", outValid, 0);
    tick();                                   // second accept
    inValid = 1'b0;
    check("b2b_acc2", inReady, 0);
    check("b2b_opa2", aluOperandA, a2[7:0]);
    for (int i = 0; i < LANES; i++) tick();
    check("b2b_vld2", outValid, 1);
    check("b2b_vec2", outVector, e2);
    tick();

    // Randomized instructions against the reference model.
    for (int k = 0; k < 14; k++) begin
      rf = ALUOP'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      run_op($sformatf("rnd%0d", k), rf, ra, rb, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
